ascii_to_morse_tx: RTL and testbench

// - Transmit side of the Morse link: accepts one ASCII character per valid/ready handshake and

---
 rtl/ascii_to_morse_tx_pkg.sv | 20 ++
 rtl/ascii_to_morse_tx_lut.sv | 57 +++++
 rtl/ascii_to_morse_tx.sv | 82 ++++++++
 tb/tb_ascii_to_morse_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ascii_to_morse_tx_pkg.sv
// ascii_to_morse_tx_pkg: shared FSM states, Morse unit multipliers, ASCII constants and code-word layout
package ascii_to_morse_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP, S_DONE} state_t;
  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int CGAP_UNITS = 3;
  localparam int WGAP_UNITS = 4;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7a;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam int LEN_W = 3;
  localparam int PAT_W = 5;
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } code_t;
endpackage

// File: rtl/ascii_to_morse_tx_lut.sv
// ascii_to_morse_tx_lut: combinational ASCII -> {valid, len, pattern} Morse encoder
// Ports: i_char (ASCII in), o_code (valid, element count, dash bitmap with first element in bit 0).
// Space encodes as valid with len 0. Digits are encoded only when MORSE_DIGITS_EN is defined.
module ascii_to_morse_tx_lut
  import ascii_to_morse_tx_pkg::*;
(
  input  logic [7:0] i_char,
  output code_t      o_code
);
  logic [7:0] w_up;
  always_comb begin
    w_up = (i_char >= ASCII_LA && i_char <= ASCII_LZ) ? i_char - 8'h20 : i_char;
    o_code = '0;
    case (w_up)
      ASCII_SPACE: o_code = {1'b1, 3'd0, 5'b00000};
      "A": o_code = {1'b1, 3'd2, 5'b00010};
      "B": o_code = {1'b1, 3'd4, 5'b00001};
      "C": o_code = {1'b1, 3'd4, 5'b00101};
      "D": o_code = {1'b1, 3'd3, 5'b00001};
      "E": o_code = {1'b1, 3'd1, 5'b00000};
      "F": o_code = {1'b1, 3'd4, 5'b00100};
      "G": o_code = {1'b1, 3'd3, 5'b00011};
      "H": o_code = {1'b1, 3'd4, 5'b00000};
      "I": o_code = {1'b1, 3'd2, 5'b00000};
      "J": o_code = {1'b1, 3'd4, 5'b01110};
      "K": o_code = {1'b1, 3'd3, 5'b00101};
      "L": o_code = {1'b1, 3'd4, 5'b00010};
      "M": o_code = {1'b1, 3'd2, 5'b00011};
      "N": o_code = {1'b1, 3'd2, 5'b00001};
      "O": o_code = {1'b1, 3'd3, 5'b00111};
      "P": o_code = {1'b1, 3'd4, 5'b00110};
      "Q": o_code = {1'b1, 3'd4, 5'b01011};
      "R": o_code = {1'b1, 3'd3, 5'b00010};
      "S": o_code = {1'b1, 3'd3, 5'b00000};
      "T": o_code = {1'b1, 3'd1, 5'b00001};
      "U": o_code = {1'b1, 3'd3, 5'b00100};
      "V": o_code = {1'b1, 3'd4, 5'b01000};
      "W": o_code = {1'b1, 3'd3, 5'b00110};
      "X": o_code = {1'b1, 3'd4, 5'b01001};
      "Y": o_code = {1'b1, 3'd4, 5'b01101};
      "Z": o_code = {1'b1, 3'd4, 5'b00011};
`ifdef MORSE_DIGITS_EN
      "0": o_code = {1'b1, 3'd5, 5'b11111};
      "1": o_code = {1'b1, 3'd5, 5'b11110};
      "2": o_code = {1'b1, 3'd5, 5'b11100};
      "3": o_code = {1'b1, 3'd5, 5'b11000};
      "4": o_code = {1'b1, 3'd5, 5'b10000};
      "5": o_code = {1'b1, 3'd5, 5'b00000};
      "6": o_code = {1'b1, 3'd5, 5'b00001};
      "7": o_code = {1'b1, 3'd5, 5'b00011};
      "8": o_code = {1'b1, 3'd5, 5'b00111};
      "9": o_code = {1'b1, 3'd5, 5'b01111};
`endif
      default: o_code = '0;
    endcase
  end
endmodule

// File: rtl/ascii_to_morse_tx.sv
// ascii_to_morse_tx: ASCII character to Morse key-line transmitter with unit timing
// Ports: clk, rst (async, active high), char_in/char_valid/char_ready (input handshake),
//        key_out (1 = mark), busy, char_done (end-of-character pulse), bad_char (unsupported code pulse).
// Build option: MORSE_DIGITS_EN adds '0'-'9' to the encoder.
module ascii_to_morse_tx
  import ascii_to_morse_tx_pkg::*;
#(
  parameter int UNIT_CYCLES = 6_000_000,
  // wide enough for the longest interval, the 4-unit word gap
  parameter int CNT_W       = $clog2(4*UNIT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       bad_char
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_timer, w_lim;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_left;
  logic             r_ready, r_key, r_busy, r_done, r_bad;
  logic             w_accept, w_end;
  int               w_units;
  code_t            w_code;
  ascii_to_morse_tx_lut u_lut (.i_char(char_in), .o_code(w_code));
  assign w_accept   = char_valid && r_ready;
  assign char_ready = r_ready;
  assign key_out    = r_key;
  assign busy       = r_busy;
  assign char_done  = r_done;
  assign bad_char   = r_bad;
  always_comb begin
    w_units = r_state == S_MARK     ? (r_pat[0] ? DASH_UNITS : DOT_UNITS) :
              r_state == S_CHAR_GAP ? CGAP_UNITS :
              r_state == S_WORD_GAP ? WGAP_UNITS : DOT_UNITS;
    w_lim   = CNT_W'(w_units*UNIT_CYCLES - 1);
    w_end   = r_timer == w_lim;
    w_next  = r_state;
    case (r_state)
      S_IDLE:                 if (w_accept) w_next = !w_code.valid ? S_DONE : w_code.len == '0 ? S_WORD_GAP : S_MARK;
      S_MARK:                 if (w_end) w_next = r_left == LEN_W'(1) ? S_CHAR_GAP : S_ELEM_GAP;
      S_ELEM_GAP:             if (w_end) w_next = S_MARK;
      S_CHAR_GAP, S_WORD_GAP: if (w_end) w_next = S_DONE;
      default:                w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pat   <= '0;
      r_left  <= '0;
      r_ready <= 1'b0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      // timer restarts on every state entry and idles at zero
      r_timer <= (w_next == r_state && r_state != S_IDLE) ? r_timer + 1'b1 : '0;
      if (r_state == S_IDLE && w_accept) begin
        r_pat  <= w_code.pattern;
        r_left <= w_code.len;
      end else if (r_state == S_MARK && w_end) begin
        r_pat  <= r_pat >> 1;
        r_left <= r_left - 1'b1;
      end
      r_ready <= w_next == S_IDLE;
      r_key   <= w_next == S_MARK;
      r_busy  <= w_next != S_IDLE;
      r_done  <= w_next == S_DONE;
      // only an unsupported code jumps straight from IDLE to DONE
      r_bad   <= w_next == S_DONE && r_state == S_IDLE;
    end
  end
endmodule

// File: tb/tb_ascii_to_morse_tx.sv
// tb_ascii_to_morse_tx: table, random and corner-case checks of ascii_to_morse_tx against a Morse timing model
module tb_ascii_to_morse_tx;
  localparam int U = 4;
  logic       clk = 1'b0, rst = 1'b1, char_valid = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_ready, key_out, busy, char_done, bad_char;
  int         checks = 0, errors = 0;
  bit         exp_q[$];
  bit         exp_bad;
  typedef struct {
    logic [7:0] c;
    int         high;
    int         len;
    bit         bad;
  } vec_t;
  vec_t tbl[12];
  string itu_l[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
                       "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
`ifdef MORSE_DIGITS_EN
  string itu_d[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
`endif

  always #5 clk = ~clk;

  ascii_to_morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .key_out(key_out), .busy(busy), .char_done(char_done), .bad_char(bad_char)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] c);
    logic [7:0] u;
    string      code;
    bit         ok;
    exp_q.delete();
    exp_bad = 1'b0;
    ok = 1'b0;
    code = "";
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (u == 8'h20) begin
      repeat (4*U) exp_q.push_back(1'b0);
      return;
    end
    if (u >= "A" && u <= "Z") begin code = itu_l[u - 8'h41]; ok = 1'b1; end
`ifdef MORSE_DIGITS_EN
    if (u >= "0" && u <= "9") begin code = itu_d[u - 8'h30]; ok = 1'b1; end
`endif
    if (!ok) begin
      exp_bad = 1'b1;
      return;
    end
    for (int k = 0; k < code.len(); k++) begin
      repeat (code[k] == "-" ? 3*U : U) exp_q.push_back(1'b1);
      if (k < code.len() - 1) repeat (U) exp_q.push_back(1'b0);
    end
    repeat (3*U) exp_q.push_back(1'b0);
  endfunction

  task automatic send(input logic [7:0] c, input bit hold);
    int n = 0;
    while (char_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check($sformatf("ready_wait_%02h", c), char_ready, 1);
    char_valid = 1'b1;
    char_in = c;
    model(c);
    @(posedge clk); #1;
    if (!hold) char_valid = 1'b0;
  endtask

  task automatic check_trace(input string name, output int high, output int done_at);
    int L, badc;
    bit ek;
    L = exp_q.size();
    badc = 0;
    high = 0;
    done_at = -1;
    for (int i = 0; i <= L; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      ek = (i < L) ? exp_q[i] : 1'b0;
      high += int'(key_out === 1'b1);
      if (char_done === 1'b1 && done_at < 0) done_at = i;
      if (i < L && (key_out !== ek || char_done !== 1'b0 || bad_char !== 1'b0 || busy !== 1'b1 || char_ready !== 1'b0))
        badc++;
    end
    check($sformatf("%s wrong_trace_cycles", name), badc, 0);
    check($sformatf("%s char_done", name), char_done, 1);
    check($sformatf("%s bad_char", name), bad_char, exp_bad);
    check($sformatf("%s key_at_done", name), key_out, 0);
    @(posedge clk); #1;
    check($sformatf("%s ready_after", name), char_ready, 1);
    check($sformatf("%s busy_after", name), busy, 0);
  endtask

  initial begin
    int hi, dn, cnt;
    logic [7:0] c;
    tbl = '{'{8'h45, 4, 16, 0}, '{8'h61, 16, 32, 0}, '{8'h41, 16, 32, 0}, '{8'h20, 0, 16, 0},
            '{8'h23, 0, 0, 1}, '{8'h54, 12, 24, 0}, '{8'h4F, 36, 56, 0}, '{8'h51, 40, 64, 0},
            '{8'h7A, 32, 56, 0}, '{8'h40, 0, 0, 1}, '{8'h7B, 0, 0, 1},
`ifdef MORSE_DIGITS_EN
            '{8'h35, 20, 48, 0}};
`else
            '{8'h35, 0, 0, 1}};
`endif
    #1;
    check("reset key_out", key_out, 0);
    check("reset char_ready", char_ready, 0);
    check("reset busy", busy, 0);
    check("reset char_done", char_done, 0);
    check("reset bad_char", bad_char, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_before_first_edge", char_ready, 0);
    @(posedge clk); #1;
    check("ready_first_edge", char_ready, 1);

    foreach (tbl[i]) begin
      send(tbl[i].c, 1'b0);
      check_trace($sformatf("tbl_%02h", tbl[i].c), hi, dn);
      check($sformatf("tbl_%02h high_cycles", tbl[i].c), hi, tbl[i].high);
      check($sformatf("tbl_%02h done_cycle", tbl[i].c), dn, tbl[i].len);
      check($sformatf("tbl_%02h model_bad", tbl[i].c), {31'd0, exp_bad}, {31'd0, tbl[i].bad});
    end

    for (int r = 0; r < 30; r++) begin
      c = $urandom_range(0, 1) ? (8'h41 + 8'($urandom_range(0, 25))) | ($urandom_range(0, 1) ? 8'h20 : 8'h00)
                               : 8'($urandom_range(0, 127));
      send(c, 1'b0);
      check_trace($sformatf("rnd%0d_%02h", r, c), hi, dn);
    end

    send("T", 1'b1);
    char_in = "E";
    check_trace("held_T", hi, dn);
    check("held_T high", hi, 12);
    model("E");
    @(posedge clk); #1;
    char_valid = 1'b0;
    check_trace("held_E", hi, dn);
    check("held_E high", hi, 4);

    send("T", 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset key_out", key_out, 1);
    rst = 1'b1;
    #1;
    check("mid_reset key_out", key_out, 0);
    check("mid_reset busy", busy, 0);
    check("mid_reset ready", char_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset ready_before_edge", char_ready, 0);
    @(posedge clk); #1;
    check("post_reset ready", char_ready, 1);
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      cnt += int'(char_done === 1'b1) + int'(key_out === 1'b1) + int'(busy === 1'b1);
    end
    check("post_reset silent_cycles_active", cnt, 0);

    send("e", 1'b0);
    check_trace("after_reset_e", hi, dn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
